// File: rtl/if_stage.sv
// Instruction-fetch stage: holds the PC, reads the instruction from a local
// word-addressed memory, and picks the next PC from sequential, stall and
// branch-redirect inputs. A three-state control FSM handles boot, run and halt.
//
// Control inputs: Stall and PCSrc are level signals sampled on each rising
// edge. There is no ready path. In RUN, PCSrc wins over Stall. In BOOT, both
// are ignored. In HALT, Stall is ignored and only PCSrc leaves HALT. A fetch
// is accepted, and counted, on an edge where Fetch_Valid=1, Stall=0 and
// PCSrc=0.
module if_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          IMEM_WORDS = 1024,
  parameter logic [31:0] NOP_INST   = 32'h00000013,
  localparam int         AW         = $clog2(IMEM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Stall,
  input  logic          PCSrc,
  input  logic [63:0]   Branch_Target,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_wdata,
  output logic [63:0]   PC_Out,
  output logic [31:0]   Instruction,
  output logic          Fetch_Valid,
  output logic          Halted,
  output logic          Fault,
  output logic [31:0]   Fetch_Count,
  output logic [1:0]    fsm_state
);

  localparam logic [31:0] EBREAK_INST = 32'h00100073;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      state;
  logic [63:0] pc;
  logic [31:0] fetch_count;
  logic        fault;
  logic [31:0] mem [IMEM_WORDS];
  logic [31:0] mem_word;
  logic        bad_fetch;
  logic        fetch_valid;
  logic        accept;

  // Bad fetch: misaligned PC, or any PC bit above the memory range is set.
  always_comb begin
    bad_fetch = 1'b0;
    if (pc[1:0] != 2'b00) bad_fetch = 1'b1;
    if (|pc[63:AW+2])     bad_fetch = 1'b1;
  end

  // Combinational instruction read. Bad fetches and non-RUN states show a bubble.
  always_comb begin
    mem_word    = mem[pc[AW+1:2]];
    fetch_valid = (state == ST_RUN) && !bad_fetch;
    Instruction = fetch_valid ? mem_word : NOP_INST;
    accept      = fetch_valid && !Stall && !PCSrc;
  end

  // Loader port. Memory has no reset, so contents survive a pipeline reset.
  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
  end

  // Control FSM and PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (PCSrc) begin
            pc <= Branch_Target;
          end else if (bad_fetch) begin
            // Hold the offending PC so it is visible while halted.
            state <= ST_HALT;
            fault <= 1'b1;
          end else if (Stall) begin
            pc <= pc;
          end else if (Instruction == EBREAK_INST) begin
            pc    <= pc + 64'd4;
            state <= ST_HALT;
          end else begin
            pc <= pc + 64'd4;
          end
        end
        ST_HALT: begin
          if (PCSrc) begin
            pc    <= Branch_Target;
            fault <= 1'b0;
            state <= ST_RUN;
          end
        end
        default: begin
          state <= ST_HALT;
        end
      endcase
    end
  end

  // Accepted-fetch counter. It saturates and does not wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= 32'd0;
    end else if (accept && (fetch_count != 32'hFFFF_FFFF)) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  assign PC_Out      = pc;
  assign Fetch_Valid = fetch_valid;
  assign Halted      = (state == ST_HALT);
  assign Fault       = fault;
  assign Fetch_Count = fetch_count;
  assign fsm_state   = state;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a table of per-cycle vectors plus hand-written
// sequences for reset, async reset mid-run and the loader write timing.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] I0  = 32'h00500093;
  localparam logic [31:0] I1  = 32'h00100113;
  localparam logic [31:0] I2  = 32'h002081B3;
  localparam logic [31:0] I4  = 32'h00400213;
  localparam logic [31:0] EBR = 32'h00100073;
  localparam logic [31:0] W8  = 32'h00208233;
  localparam logic [31:0] W16 = 32'h00000517;

  logic        clk;
  logic        reset;
  logic        Stall;
  logic        PCSrc;
  logic [63:0] Branch_Target;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [63:0] PC_Out;
  logic [31:0] Instruction;
  logic        Fetch_Valid;
  logic        Halted;
  logic        Fault;
  logic [31:0] Fetch_Count;
  logic [1:0]  fsm_state;

  int total;
  int bad;

  if_stage #(
    .RESET_PC   (64'h0),
    .IMEM_WORDS (1024),
    .NOP_INST   (32'h00000013)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .Stall         (Stall),
    .PCSrc         (PCSrc),
    .Branch_Target (Branch_Target),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .PC_Out        (PC_Out),
    .Instruction   (Instruction),
    .Fetch_Valid   (Fetch_Valid),
    .Halted        (Halted),
    .Fault         (Fault),
    .Fetch_Count   (Fetch_Count),
    .fsm_state     (fsm_state)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Vector: inputs for the cycle, then outputs expected during that cycle.
  typedef struct {
    logic        st;
    logic        ps;
    logic [63:0] tgt;
    logic [63:0] pc;
    logic [31:0] inst;
    logic        v;
    logic        h;
    logic        f;
    logic [31:0] cnt;
  } vec_t;

  vec_t vt[22];

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic load_word(input int idx, input logic [31:0] data);
    imem_we    = 1'b1;
    imem_addr  = idx[9:0];
    imem_wdata = data;
    @(posedge clk);
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    Stall = 1'b0;
    PCSrc = 1'b0;
    Branch_Target = 64'h0;
    imem_we = 1'b0;
    imem_addr = '0;
    imem_wdata = '0;

    //          st    ps    tgt        pc          inst v     h     f     cnt
    vt[0]  = '{1'b0, 1'b1, 64'h40,   64'h0,      NOP, 1'b0, 1'b0, 1'b0, 32'd0};
    vt[1]  = '{1'b0, 1'b0, 64'h0,    64'h0,      I0,  1'b1, 1'b0, 1'b0, 32'd0};
    vt[2]  = '{1'b0, 1'b0, 64'h0,    64'h4,      I1,  1'b1, 1'b0, 1'b0, 32'd1};
    vt[3]  = '{1'b0, 1'b0, 64'h0,    64'h8,      I2,  1'b1, 1'b0, 1'b0, 32'd2};
    vt[4]  = '{1'b0, 1'b0, 64'h0,    64'hC,      NOP, 1'b1, 1'b0, 1'b0, 32'd3};
    vt[5]  = '{1'b0, 1'b1, 64'h8,    64'h10,     I4,  1'b1, 1'b0, 1'b0, 32'd4};
    vt[6]  = '{1'b1, 1'b0, 64'h0,    64'h8,      I2,  1'b1, 1'b0, 1'b0, 32'd4};
    vt[7]  = '{1'b1, 1'b0, 64'h0,    64'h8,      I2,  1'b1, 1'b0, 1'b0, 32'd4};
    vt[8]  = '{1'b0, 1'b0, 64'h0,    64'h8,      I2,  1'b1, 1'b0, 1'b0, 32'd4};
    vt[9]  = '{1'b1, 1'b1, 64'h40,   64'hC,      NOP, 1'b1, 1'b0, 1'b0, 32'd5};
    vt[10] = '{1'b0, 1'b1, 64'h10,   64'h40,     W16, 1'b1, 1'b0, 1'b0, 32'd5};
    vt[11] = '{1'b0, 1'b0, 64'h0,    64'h10,     I4,  1'b1, 1'b0, 1'b0, 32'd5};
    vt[12] = '{1'b0, 1'b0, 64'h0,    64'h14,     EBR, 1'b1, 1'b0, 1'b0, 32'd6};
    vt[13] = '{1'b1, 1'b0, 64'h0,    64'h18,     NOP, 1'b0, 1'b1, 1'b0, 32'd7};
    vt[14] = '{1'b0, 1'b1, 64'h0,    64'h18,     NOP, 1'b0, 1'b1, 1'b0, 32'd7};
    vt[15] = '{1'b0, 1'b1, 64'h2,    64'h0,      I0,  1'b1, 1'b0, 1'b0, 32'd7};
    vt[16] = '{1'b0, 1'b0, 64'h0,    64'h2,      NOP, 1'b0, 1'b0, 1'b0, 32'd7};
    vt[17] = '{1'b0, 1'b1, 64'h10,   64'h2,      NOP, 1'b0, 1'b1, 1'b1, 32'd7};
    vt[18] = '{1'b0, 1'b1, 64'h1000, 64'h10,     I4,  1'b1, 1'b0, 1'b0, 32'd7};
    vt[19] = '{1'b0, 1'b0, 64'h0,    64'h1000,   NOP, 1'b0, 1'b0, 1'b0, 32'd7};
    vt[20] = '{1'b0, 1'b1, 64'h20,   64'h1000,   NOP, 1'b0, 1'b1, 1'b1, 32'd7};
    vt[21] = '{1'b0, 1'b0, 64'h0,    64'h20,     W8,  1'b1, 1'b0, 1'b0, 32'd7};

    // Preload memory while reset is held.
    @(negedge clk);
    load_word(0, I0);
    load_word(1, I1);
    load_word(2, I2);
    load_word(3, NOP);
    load_word(4, I4);
    load_word(5, EBR);
    load_word(8, W8);
    load_word(16, W16);

    // Outputs while reset is held.
    #1;
    check("rst_pc",    0, PC_Out, 64'h0);
    check("rst_inst",  0, {32'h0, Instruction}, {32'h0, NOP});
    check("rst_valid", 0, {63'h0, Fetch_Valid}, 64'h0);
    check("rst_halt",  0, {63'h0, Halted}, 64'h0);
    check("rst_fault", 0, {63'h0, Fault}, 64'h0);
    check("rst_cnt",   0, {32'h0, Fetch_Count}, 64'h0);

    // Release reset between edges. The first cycle after release is BOOT.
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 22; i++) begin
      Stall         = vt[i].st;
      PCSrc         = vt[i].ps;
      Branch_Target = vt[i].tgt;
      #1;
      check("pc",    i, PC_Out, vt[i].pc);
      check("inst",  i, {32'h0, Instruction}, {32'h0, vt[i].inst});
      check("valid", i, {63'h0, Fetch_Valid}, {63'h0, vt[i].v});
      check("halt",  i, {63'h0, Halted}, {63'h0, vt[i].h});
      check("fault", i, {63'h0, Fault}, {63'h0, vt[i].f});
      check("cnt",   i, {32'h0, Fetch_Count}, {32'h0, vt[i].cnt});
      if (i != 21) begin
        @(posedge clk);
        @(negedge clk);
      end
    end

    // Async reset mid-run at PC=0x20, asserted between edges.
    #2;
    reset = 1'b0;
    #1;
    check("arst_pc",    0, PC_Out, 64'h0);
    check("arst_cnt",   0, {32'h0, Fetch_Count}, 64'h0);
    check("arst_valid", 0, {63'h0, Fetch_Valid}, 64'h0);
    check("arst_inst",  0, {32'h0, Instruction}, {32'h0, NOP});
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("boot_pc",    0, PC_Out, 64'h0);
    check("boot_valid", 0, {63'h0, Fetch_Valid}, 64'h0);
    @(posedge clk);
    @(negedge clk);

    // The refetch shows the memory was kept. A write to the word being fetched
    // only shows up after the edge.
    Stall      = 1'b1;
    imem_we    = 1'b1;
    imem_addr  = 10'd0;
    imem_wdata = 32'hDEADBEEF;
    #1;
    check("refetch_inst", 0, {32'h0, Instruction}, {32'h0, I0});
    check("refetch_valid", 0, {63'h0, Fetch_Valid}, 64'h1);
    @(posedge clk);
    @(negedge clk);
    imem_we = 1'b0;
    #1;
    check("wr_inst", 0, {32'h0, Instruction}, 64'hDEADBEEF);
    check("wr_pc",   0, PC_Out, 64'h0);
    check("wr_cnt",  0, {32'h0, Fetch_Count}, 64'h0);
    Stall = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
